// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer: prioritises traps, ERET and synchronized interrupts,
// strobes CP0 for one cycle, then redirects the PC while stalling fetch/decode.
module exception_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall,
  input  logic        brk,
  input  logic        teq_trap,
  input  logic        eret_in,
  input  logic [31:0] pc_in,
  input  logic [5:0]  irq,
  input  logic [31:0] status_in,
  input  logic [31:0] exc_addr_in,
  output logic        exception,
  output logic [4:0]  cause,
  output logic [31:0] epc,
  output logic        eret_out,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic        stall,
  output logic [5:0]  pending,
  output logic [2:0]  irq_id
);

  typedef enum logic [1:0] {IDLE, SIGNAL, REDIRECT, ERET} state_t;

  localparam logic [4:0] CAUSE_INT = 5'b00000;
  localparam logic [4:0] CAUSE_SYS = 5'b01000;
  localparam logic [4:0] CAUSE_BRK = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ = 5'b01101;

  state_t      state_q, state_d;
  logic [5:0]  sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [5:0]  pending_q, pending_d;
  logic        exception_q, exception_d;
  logic [4:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [2:0]  irq_id_q, irq_id_d;
  logic        irq_take_q, irq_take_d;
  logic        eret_out_q, eret_out_d;
  logic        pc_redirect_q, pc_redirect_d;
  logic        stall_q, stall_d;

  logic        gie, take_sys, take_brk, take_teq;
  logic [5:0]  irq_rise, irq_clr, irq_act;
  logic [2:0]  irq_idx;
  logic        unused_status;

  assign unused_status = ^{status_in[31:16], status_in[9:4]};

  always_comb begin
    sync1_d  = irq;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    irq_rise = sync2_q & ~sync3_q;

    // A fresh edge in the clearing cycle wins over the clear.
    irq_clr   = (state_q == SIGNAL && irq_take_q) ? (6'b000001 << irq_id_q) : 6'b000000;
    pending_d = (pending_q & ~irq_clr) | irq_rise;

    gie      = status_in[0];
    take_sys = syscall  & gie & status_in[1];
    take_brk = brk      & gie & status_in[2];
    take_teq = teq_trap & gie & status_in[3];
    irq_act  = pending_q & status_in[15:10] & {6{gie}};

    irq_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (irq_act[i]) irq_idx = 3'(i);
    end

    state_d       = state_q;
    exception_d   = 1'b0;
    cause_d       = 5'd0;
    epc_d         = 32'd0;
    irq_id_d      = 3'd0;
    irq_take_d    = 1'b0;
    eret_out_d    = 1'b0;
    pc_redirect_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (take_sys || take_brk || take_teq) begin
          state_d     = SIGNAL;
          exception_d = 1'b1;
          epc_d       = pc_in;
          cause_d     = take_sys ? CAUSE_SYS : (take_brk ? CAUSE_BRK : CAUSE_TEQ);
        end else if (eret_in) begin
          state_d       = ERET;
          eret_out_d    = 1'b1;
          pc_redirect_d = 1'b1;
        end else if (|irq_act) begin
          state_d     = SIGNAL;
          exception_d = 1'b1;
          epc_d       = pc_in;
          cause_d     = CAUSE_INT;
          irq_id_d    = irq_idx;
          irq_take_d  = 1'b1;
        end
      end
      SIGNAL: begin
        state_d       = REDIRECT;
        pc_redirect_d = 1'b1;
      end
      REDIRECT: state_d = IDLE;
      ERET:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sync1_q       <= '0;
      sync2_q       <= '0;
      sync3_q       <= '0;
      pending_q     <= '0;
      exception_q   <= 1'b0;
      cause_q       <= '0;
      epc_q         <= '0;
      irq_id_q      <= '0;
      irq_take_q    <= 1'b0;
      eret_out_q    <= 1'b0;
      pc_redirect_q <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync3_q       <= sync3_d;
      pending_q     <= pending_d;
      exception_q   <= exception_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      irq_id_q      <= irq_id_d;
      irq_take_q    <= irq_take_d;
      eret_out_q    <= eret_out_d;
      pc_redirect_q <= pc_redirect_d;
      stall_q       <= stall_d;
    end
  end

  assign exception     = exception_q;
  assign cause         = cause_q;
  assign epc           = epc_q;
  assign irq_id        = irq_id_q;
  assign eret_out      = eret_out_q;
  assign pc_redirect   = pc_redirect_q;
  assign redirect_addr = pc_redirect_q ? exc_addr_in : 32'd0;
  assign stall         = stall_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: vector table for single events plus hand-built
// interrupt/reset sequences, all checked through an expected-output queue.
module tb_exception_ctrl;

  logic        clk, rst;
  logic        syscall, brk, teq_trap, eret_in;
  logic [31:0] pc_in, status_in, exc_addr_in;
  logic [5:0]  irq;
  logic        exception, eret_out, pc_redirect, stall;
  logic [4:0]  cause;
  logic [31:0] epc, redirect_addr;
  logic [5:0]  pending;
  logic [2:0]  irq_id;

  exception_ctrl dut (
    .clk(clk), .rst(rst), .syscall(syscall), .brk(brk), .teq_trap(teq_trap),
    .eret_in(eret_in), .pc_in(pc_in), .irq(irq), .status_in(status_in),
    .exc_addr_in(exc_addr_in), .exception(exception), .cause(cause), .epc(epc),
    .eret_out(eret_out), .pc_redirect(pc_redirect), .redirect_addr(redirect_addr),
    .stall(stall), .pending(pending), .irq_id(irq_id)
  );

  typedef struct packed {
    logic        exception;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic        eret_out;
    logic        pc_redirect;
    logic [31:0] redirect_addr;
    logic        stall;
    logic [2:0]  irq_id;
    logic [5:0]  pending;
  } obs_t;

  typedef struct {
    logic        sys, brk, teq, eret;
    logic [31:0] status, pc, exc_addr;
    int          kind;   // 0 no event, 1 exception, 2 eret
    logic [4:0]  cause;
    string       name;
  } vec_t;

  localparam logic [31:0] HANDLER = 32'h8000_0180;

  obs_t sb[$];
  int   checks = 0;
  int   passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1);
  end

  function automatic obs_t mk(logic ex, logic [4:0] c, logic [31:0] e, logic er,
                              logic pr, logic [31:0] ra, logic st, logic [2:0] id,
                              logic [5:0] p);
    obs_t o;
    o.exception = ex; o.cause = c; o.epc = e; o.eret_out = er; o.pc_redirect = pr;
    o.redirect_addr = ra; o.stall = st; o.irq_id = id; o.pending = p;
    return o;
  endfunction

  function automatic obs_t idle_obs(logic [5:0] p);
    return mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 3'd0, p);
  endfunction

  function automatic vec_t mkv(logic s, logic b, logic t, logic e, logic [31:0] st,
                               logic [31:0] pc, logic [31:0] ea, int k, logic [4:0] c,
                               string n);
    vec_t v;
    v.sys = s; v.brk = b; v.teq = t; v.eret = e; v.status = st; v.pc = pc;
    v.exc_addr = ea; v.kind = k; v.cause = c; v.name = n;
    return v;
  endfunction

  task automatic check_now(string name);
    obs_t act, exp;
    act = {exception, cause, epc, eret_out, pc_redirect, redirect_addr, stall, irq_id, pending};
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s: output %h seen with no expected entry queued", name, act);
    end else begin
      exp = sb.pop_front();
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(string name);
    @(negedge clk);
    check_now(name);
    syscall = 1'b0; brk = 1'b0; teq_trap = 1'b0; eret_in = 1'b0;
  endtask

  task automatic idle_steps(int n, logic [5:0] p, string name);
    for (int k = 0; k < n; k++) begin
      sb.push_back(idle_obs(p));
      step(name);
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = mkv(1,0,0,0, 32'h3, 32'h0040_0010, HANDLER, 1, 5'b01000, "syscall");
    vecs[1]  = mkv(0,1,0,0, 32'h5, 32'h0040_0020, HANDLER, 1, 5'b01001, "brk");
    vecs[2]  = mkv(0,0,1,0, 32'h9, 32'h0040_0030, HANDLER, 1, 5'b01101, "teq");
    vecs[3]  = mkv(0,1,0,0, 32'h3, 32'h0040_0040, HANDLER, 0, 5'b00000, "brk_masked");
    vecs[4]  = mkv(0,0,0,1, 32'h0, 32'h0040_0050, 32'h0040_0014, 2, 5'b00000, "eret");
    vecs[5]  = mkv(1,1,1,0, 32'hF, 32'h0040_0060, HANDLER, 1, 5'b01000, "prio_sys");
    vecs[6]  = mkv(0,1,1,1, 32'hF, 32'h0040_0070, HANDLER, 1, 5'b01001, "prio_brk");
    vecs[7]  = mkv(0,0,1,1, 32'h9, 32'h0040_0080, HANDLER, 1, 5'b01101, "prio_teq");
    vecs[8]  = mkv(1,0,0,1, 32'h2, 32'h0040_0090, 32'h0040_0A00, 2, 5'b00000, "gie_off_eret");
    vecs[9]  = mkv(1,0,0,0, 32'hE, 32'h0040_00A0, HANDLER, 0, 5'b00000, "gie_off_sys");
    vecs[10] = mkv(0,1,0,1, 32'h1, 32'h0040_00B0, 32'h0040_0B00, 2, 5'b00000, "eret_over_masked");

    rst = 1'b1; syscall = 1'b0; brk = 1'b0; teq_trap = 1'b0; eret_in = 1'b0;
    pc_in = '0; irq = '0; status_in = '0; exc_addr_in = HANDLER;
    repeat (2) @(negedge clk);
    sb.push_back(idle_obs(6'd0));
    check_now("reset_state");
    rst = 1'b0;
    idle_steps(2, 6'd0, "post_reset");

    for (int v = 0; v < 11; v++) begin
      syscall = vecs[v].sys; brk = vecs[v].brk; teq_trap = vecs[v].teq;
      eret_in = vecs[v].eret; status_in = vecs[v].status; pc_in = vecs[v].pc;
      exc_addr_in = vecs[v].exc_addr;
      if (vecs[v].kind == 1) begin
        sb.push_back(mk(1, vecs[v].cause, vecs[v].pc, 0, 0, 32'd0, 1, 3'd0, 6'd0));
        sb.push_back(mk(0, 5'd0, 32'd0, 0, 1, vecs[v].exc_addr, 1, 3'd0, 6'd0));
        sb.push_back(idle_obs(6'd0));
        repeat (3) step(vecs[v].name);
      end else if (vecs[v].kind == 2) begin
        sb.push_back(mk(0, 5'd0, 32'd0, 1, 1, vecs[v].exc_addr, 1, 3'd0, 6'd0));
        sb.push_back(idle_obs(6'd0));
        repeat (2) step(vecs[v].name);
      end else begin
        sb.push_back(idle_obs(6'd0));
        step(vecs[v].name);
      end
    end

    // Syscall and irq[2] edge together; irq[2] masked until bit 12 is set.
    exc_addr_in = HANDLER; status_in = 32'h0000_0403; pc_in = 32'h0040_0100;
    syscall = 1'b1; irq = 6'b000100;
    sb.push_back(mk(1, 5'b01000, 32'h0040_0100, 0, 0, 32'd0, 1, 3'd0, 6'd0));
    sb.push_back(mk(0, 5'd0, 32'd0, 0, 1, HANDLER, 1, 3'd0, 6'd0));
    repeat (2) step("sys_with_irq2");
    idle_steps(2, 6'b000100, "irq2_masked_pending");
    status_in = 32'h0000_1403; pc_in = 32'h0040_0200;
    sb.push_back(mk(1, 5'd0, 32'h0040_0200, 0, 0, 32'd0, 1, 3'd2, 6'b000100));
    sb.push_back(mk(0, 5'd0, 32'd0, 0, 1, HANDLER, 1, 3'd0, 6'd0));
    repeat (2) step("irq2_taken");
    irq = 6'd0;
    idle_steps(3, 6'd0, "irq2_done");

    // irq[0] and irq[5] rise together: lowest index first.
    status_in = 32'h0000_8401; pc_in = 32'h0040_0300; irq = 6'b100001;
    idle_steps(2, 6'd0, "irq05_sync");
    idle_steps(1, 6'b100001, "irq05_pending");
    sb.push_back(mk(1, 5'd0, 32'h0040_0300, 0, 0, 32'd0, 1, 3'd0, 6'b100001));
    sb.push_back(mk(0, 5'd0, 32'd0, 0, 1, HANDLER, 1, 3'd0, 6'b100000));
    sb.push_back(idle_obs(6'b100000));
    sb.push_back(mk(1, 5'd0, 32'h0040_0300, 0, 0, 32'd0, 1, 3'd5, 6'b100000));
    sb.push_back(mk(0, 5'd0, 32'd0, 0, 1, HANDLER, 1, 3'd0, 6'd0));
    repeat (5) step("irq05_service");
    irq = 6'd0;
    idle_steps(3, 6'd0, "irq05_done");

    // Reset in the middle of SIGNAL with a masked interrupt pending.
    status_in = 32'h3; irq = 6'b000010;
    idle_steps(2, 6'd0, "irq1_sync");
    idle_steps(1, 6'b000010, "irq1_pending");
    irq = 6'd0;
    idle_steps(3, 6'b000010, "irq1_hold");
    syscall = 1'b1; pc_in = 32'h0040_0400;
    sb.push_back(mk(1, 5'b01000, 32'h0040_0400, 0, 0, 32'd0, 1, 3'd0, 6'b000010));
    step("sys_before_rst");
    #2 rst = 1'b1;
    #1 sb.push_back(idle_obs(6'd0));
    check_now("rst_mid_signal");
    @(negedge clk);
    sb.push_back(idle_obs(6'd0));
    check_now("rst_held");
    rst = 1'b0;
    idle_steps(3, 6'd0, "no_reissue");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL: clk  input  1  system clock; all state updates on the rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL: syscall  input  1  decoded SYSCALL, valid in the current cycle.
REQ-004 SHALL: brk  input  1  decoded BREAK, valid in the current cycle.
REQ-005 SHALL: teq_trap  input  1  TEQ with equal operands, valid in the current cycle.
REQ-006 SHALL: eret_in  input  1  decoded ERET, valid in the current cycle.
REQ-007 SHALL: pc_in  input  32  PC of the instruction presented this cycle.
REQ-008 SHALL: irq  input  6  asynchronous external interrupt lines.
REQ-009 SHALL: status_in  input  32  CP0 Status value.
REQ-010 SHALL: exc_addr_in  input  32  CP0 handler/return address (combinational from CP0).
REQ-011 SHALL: exception  output  1  one-cycle exception strobe to CP0.
REQ-012 SHALL: cause  output  5  exception code to CP0.
REQ-013 SHALL: epc  output  32  PC handed to CP0 with the strobe.
REQ-014 SHALL: eret_out  output  1  one-cycle ERET strobe to CP0.
REQ-015 SHALL: pc_redirect  output  1  load redirect_addr into PC this cycle.
REQ-016 SHALL: redirect_addr  output  32  next PC value when pc_redirect=1.
REQ-017 SHALL: stall  output  1  freeze fetch/decode; the decoder holds its inputs while stall=1.
REQ-018 SHALL: pending  output  6  latched pending-interrupt bits.
REQ-019 SHALL: irq_id  output  3  index of the interrupt taken; 0 when the cause is not an interrupt.

Function
REQ-020 SHALL: irq pass through a 2-flop synchronizer per line; a 0->1 edge on a synchronized line sets its pending bit.
REQ-021 SHALL: a pending bit clear only in the SIGNAL cycle that takes that interrupt; a new edge arriving in the same cycle as the clear leaves the bit set.
REQ-022 SHALL: enable gating: syscall by status_in[0]&status_in[1]; brk by status_in[0]&status_in[2]; teq_trap by status_in[0]&status_in[3]; irq[i] by status_in[0]&status_in[10+i].
REQ-023 SHALL: priority: syscall > brk > teq_trap > eret_in > enabled interrupts; among interrupts, the lowest index wins.
REQ-024 SHALL: cause codes: syscall 5'b01000, brk 5'b01001, teq_trap 5'b01101, interrupt 5'b00000.
REQ-025 SHALL: FSM states: IDLE, SIGNAL, REDIRECT, ERET; inputs are sampled only in IDLE and ignored in all other states.
REQ-026 SHALL: IDLE -> SIGNAL on any enabled exception or interrupt; the winning cause, pc_in and irq_id are latched.
REQ-027 SHALL: SIGNAL: exception=1, cause/epc/irq_id driven from the latched values, stall=1; unconditional transition to REDIRECT.
REQ-028 SHALL: REDIRECT: pc_redirect=1, redirect_addr=exc_addr_in, stall=1; unconditional transition to IDLE.
REQ-029 SHALL: IDLE -> ERET on an eret_in with no higher-priority event pending.
REQ-030 SHALL: ERET: eret_out=1, pc_redirect=1, redirect_addr=exc_addr_in (CP0 EPC+4), stall=1; unconditional transition to IDLE.
REQ-031 SHALL: a full exception costs 2 cycles (strobe then redirect); a full ERET costs 1 cycle.
REQ-032 SHALL: stall=0, exception=0, eret_out=0, pc_redirect=0 in IDLE.
REQ-033 SHALL: an interrupt masked at sample time stay pending and be taken once it is enabled.

Reset
REQ-034 SHALL: rst force the FSM to IDLE and clear the synchronizers, pending, and the latched cause/epc/irq_id.
REQ-035 SHALL: all outputs read 0 during and directly after reset, including a reset asserted mid-SIGNAL/REDIRECT/ERET; the aborted strobe is not reissued.

Verification
REQ-036 SHALL: status_in=32'h3, syscall=1, pc_in=32'h0040_0010 -> next cycle exception=1, cause=01000, epc=32'h0040_0010; following cycle pc_redirect=1, redirect_addr=exc_addr_in.
REQ-037 SHALL: syscall=1 and irq[2] edge in the same cycle, status_in=32'h0000_0403 -> syscall serviced first; pending[2] stays 1; interrupt taken after return to IDLE with cause=0, irq_id=2.
REQ-038 SHALL: brk=1 with status_in[2]=0 -> no strobe, stall stays 0.
REQ-039 SHALL: eret_in=1, exc_addr_in=32'h0040_0014 -> next cycle eret_out=1, pc_redirect=1, redirect_addr=32'h0040_0014; back to IDLE one cycle later.
REQ-040 SHALL: irq[0] and irq[5] rise together, both enabled -> irq 0 taken first, then irq 5; pending returns to 0.
REQ-041 SHALL: rst pulse during the SIGNAL cycle -> outputs 0 immediately, FSM in IDLE, pending=0.
